// File: rtl/bus_timer.sv
// Memory-mapped 64-bit timer with an 8-bit prescaler, a 64-bit compare register and a sticky match flag.
// Zero-wait-state combinational reads; byte-masked writes land on the rising clock edge.
module bus_timer #(
   parameter logic [31:0] BASE_ADDRESS = 32'h0001_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] bus_address,
   output logic [31:0] bus_read_data,
   input  logic [31:0] bus_write_data,
   input  logic [3:0]  bus_byte_enable,
   input  logic        bus_read_enable,
   input  logic        bus_write_enable,
   output logic        timer_irq
);

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned TIME_W   = 64;
   localparam int unsigned PRESC_W  = 8;
   localparam logic [WORD_W-1:0] CTRL_MASK = 32'h0000_FF03;

   localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
   localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] OFF_CTRL        = 3'd4;
   localparam logic [2:0] OFF_STATUS      = 3'd5;

   logic                sel;
   logic                wr;
   logic [2:0]          offset;
   logic                tick;
   logic                match;
   logic                clr;
   logic                ctrl_en;
   logic                ctrl_irq_en;
   logic [PRESC_W-1:0]  ctrl_prescale;

   logic [TIME_W-1:0]   mtime_q,    mtime_d;
   logic [TIME_W-1:0]   mtimecmp_q, mtimecmp_d;
   logic [WORD_W-1:0]   ctrl_q,     ctrl_d;
   logic [PRESC_W-1:0]  count_q,    count_d;
   logic                pending_q,  pending_d;

   // The two low address bits are byte lanes and carry no register selection.
   logic unused_addr_bits;
   assign unused_addr_bits = ^bus_address[1:0];

   function automatic logic [WORD_W-1:0] merge_bytes(input logic [WORD_W-1:0] old_val,
                                                     input logic [WORD_W-1:0] new_val,
                                                     input logic [3:0]        be);
      logic [WORD_W-1:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   assign sel           = (bus_address[31:5] == BASE_ADDRESS[31:5]);
   assign offset        = bus_address[4:2];
   assign wr            = sel && bus_write_enable;
   assign ctrl_en       = ctrl_q[0];
   assign ctrl_irq_en   = ctrl_q[1];
   assign ctrl_prescale = ctrl_q[15:8];
   assign tick          = ctrl_en && (count_q == ctrl_prescale);
   assign match         = (mtime_q >= mtimecmp_q);
   assign clr           = wr && (offset == OFF_STATUS) && bus_byte_enable[0] && bus_write_data[0];
   assign timer_irq     = pending_q & ctrl_irq_en;

   // Next-state for all registers; a bus write to an mtime half suppresses that cycle's tick.
   always_comb begin
      count_d    = count_q;
      mtime_d    = mtime_q;
      mtimecmp_d = mtimecmp_q;
      ctrl_d     = ctrl_q;
      pending_d  = pending_q;

      if (!ctrl_en)  count_d = '0;
      else if (tick) count_d = '0;
      else           count_d = count_q + PRESC_W'(1);

      if (tick) mtime_d = mtime_q + TIME_W'(1);

      if (wr) begin
         unique case (offset)
            OFF_MTIME_LO:    mtime_d = {mtime_q[63:32],
                                        merge_bytes(mtime_q[31:0], bus_write_data, bus_byte_enable)};
            OFF_MTIME_HI:    mtime_d = {merge_bytes(mtime_q[63:32], bus_write_data, bus_byte_enable),
                                        mtime_q[31:0]};
            OFF_MTIMECMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], bus_write_data,
                                                             bus_byte_enable);
            OFF_MTIMECMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus_write_data,
                                                             bus_byte_enable);
            OFF_CTRL:        ctrl_d = merge_bytes(ctrl_q, bus_write_data, bus_byte_enable) & CTRL_MASK;
            default:         ;
         endcase
      end

      if (match)    pending_d = 1'b1;
      else if (clr) pending_d = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         ctrl_q     <= '0;
         count_q    <= '0;
         pending_q  <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         ctrl_q     <= ctrl_d;
         count_q    <= count_d;
         pending_q  <= pending_d;
      end
   end

   // Read data is zero when unselected so it can be OR-combined with other responders.
   always_comb begin
      bus_read_data = '0;
      if (sel && bus_read_enable) begin
         unique case (offset)
            OFF_MTIME_LO:    bus_read_data = mtime_q[31:0];
            OFF_MTIME_HI:    bus_read_data = mtime_q[63:32];
            OFF_MTIMECMP_LO: bus_read_data = mtimecmp_q[31:0];
            OFF_MTIMECMP_HI: bus_read_data = mtimecmp_q[63:32];
            OFF_CTRL:        bus_read_data = ctrl_q;
            OFF_STATUS:      bus_read_data = {31'd0, pending_q};
            default:         bus_read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: reset/byte-enable vector table, directed timing corners,
// and a randomized phase checked against a behavioural model of the register block.
module tb_bus_timer;

   localparam logic [31:0] BASE = 32'h0001_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] bus_address;
   logic [31:0] bus_read_data;
   logic [31:0] bus_write_data;
   logic [3:0]  bus_byte_enable;
   logic        bus_read_enable;
   logic        bus_write_enable;
   logic        timer_irq;

   int tests_run = 0;
   int tests_failed = 0;

   bus_timer #(.BASE_ADDRESS(BASE)) dut (
      .clock(clock), .reset(reset), .bus_address(bus_address), .bus_read_data(bus_read_data),
      .bus_write_data(bus_write_data), .bus_byte_enable(bus_byte_enable),
      .bus_read_enable(bus_read_enable), .bus_write_enable(bus_write_enable), .timer_irq(timer_irq)
   );

   always #5 clock = ~clock;

   // Behavioural model: registers as plain 64/32-bit values, prescaler as a modulo counter.
   logic [63:0] m_time, m_cmp;
   logic [31:0] m_ctrl;
   logic        m_pend;
   int unsigned m_count;

   always @(posedge clock) begin
      bit          msel, mwr, mtick, mmatch;
      int          moff;
      logic [63:0] nt, nc;
      logic [31:0] nctrl;
      if (reset) begin
         m_time = 64'd0; m_cmp = '1; m_ctrl = 32'd0; m_pend = 1'b0; m_count = 0;
      end else begin
         msel   = (bus_address[31:5] == BASE[31:5]);
         moff   = int'(bus_address[4:2]);
         mwr    = msel && bus_write_enable;
         mmatch = (m_time >= m_cmp);
         mtick  = m_ctrl[0] && (m_count == int'(m_ctrl[15:8]));
         nt = mtick ? m_time + 64'd1 : m_time;
         nc = m_cmp;
         nctrl = m_ctrl;
         if (mwr && moff <= 1) begin
            nt = m_time;
            for (int b = 0; b < 4; b++)
               if (bus_byte_enable[b]) nt[moff*32 + 8*b +: 8] = bus_write_data[8*b +: 8];
         end
         if (mwr && (moff == 2 || moff == 3)) begin
            for (int b = 0; b < 4; b++)
               if (bus_byte_enable[b]) nc[(moff-2)*32 + 8*b +: 8] = bus_write_data[8*b +: 8];
         end
         if (mwr && moff == 4) begin
            for (int b = 0; b < 4; b++)
               if (bus_byte_enable[b]) nctrl[8*b +: 8] = bus_write_data[8*b +: 8];
            nctrl = nctrl & 32'h0000_FF03;
         end
         if (mmatch) m_pend = 1'b1;
         else if (mwr && moff == 5 && bus_byte_enable[0] && bus_write_data[0]) m_pend = 1'b0;
         m_count = !m_ctrl[0] ? 0 : (mtick ? 0 : (m_count + 1) % 256);
         m_time = nt; m_cmp = nc; m_ctrl = nctrl;
      end
   end

   function automatic logic [31:0] model_read();
      if (!(bus_address[31:5] == BASE[31:5] && bus_read_enable)) return 32'd0;
      case (bus_address[4:2])
         3'd0: return m_time[31:0];
         3'd1: return m_time[63:32];
         3'd2: return m_cmp[31:0];
         3'd3: return m_cmp[63:32];
         3'd4: return m_ctrl;
         3'd5: return {31'd0, m_pend};
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic drive(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [31:0] data, input logic [3:0] be);
      bus_address = addr; bus_read_enable = rd; bus_write_enable = wr;
      bus_write_data = data; bus_byte_enable = be;
   endtask

   task automatic idle();
      drive(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
   endtask

   function automatic logic [31:0] reg_addr(input int off);
      return BASE + 32'(off * 4);
   endfunction

   task automatic wr_reg(input int off, input logic [31:0] data, input logic [3:0] be);
      drive(reg_addr(off), 1'b0, 1'b1, data, be);
      step();
      idle();
   endtask

   task automatic rd_chk(input string name, input int off, input logic [31:0] exp);
      drive(reg_addr(off), 1'b1, 1'b0, 32'h0, 4'h0);
      #1 check(name, bus_read_data, exp);
      step();
      idle();
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
   endtask

   typedef struct {
      bit          is_wr;
      int          off;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[16];

   logic [31:0] cur, prev, hi_before;
   int          last_change;
   bit          found;

   initial begin
      vecs[0]  = '{0, 0, 32'h0, 4'h0, 32'h0000_0000, "rst_mtime_lo"};
      vecs[1]  = '{0, 1, 32'h0, 4'h0, 32'h0000_0000, "rst_mtime_hi"};
      vecs[2]  = '{0, 2, 32'h0, 4'h0, 32'hFFFF_FFFF, "rst_cmp_lo"};
      vecs[3]  = '{0, 3, 32'h0, 4'h0, 32'hFFFF_FFFF, "rst_cmp_hi"};
      vecs[4]  = '{0, 4, 32'h0, 4'h0, 32'h0000_0000, "rst_ctrl"};
      vecs[5]  = '{0, 5, 32'h0, 4'h0, 32'h0000_0000, "rst_status"};
      vecs[6]  = '{1, 4, 32'hAAAA_AAAA, 4'b0010, 32'h0, ""};
      vecs[7]  = '{0, 4, 32'h0, 4'h0, 32'h0000_AA00, "ctrl_be_byte1"};
      vecs[8]  = '{1, 4, 32'hFFFF_FF02, 4'b1111, 32'h0, ""};
      vecs[9]  = '{0, 4, 32'h0, 4'h0, 32'h0000_FF02, "ctrl_mask"};
      vecs[10] = '{1, 2, 32'h1234_5678, 4'b0101, 32'h0, ""};
      vecs[11] = '{0, 2, 32'h0, 4'h0, 32'hFF34_FF78, "cmp_lo_be"};
      vecs[12] = '{1, 1, 32'hDEAD_BEEF, 4'b1000, 32'h0, ""};
      vecs[13] = '{0, 1, 32'h0, 4'h0, 32'hDE00_0000, "mtime_hi_be"};
      vecs[14] = '{1, 6, 32'hFFFF_FFFF, 4'b1111, 32'h0, ""};
      vecs[15] = '{0, 6, 32'h0, 4'h0, 32'h0000_0000, "reserved_reads_0"};

      idle();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1 check("rst_irq", timer_irq, 0);

      foreach (vecs[i]) begin
         if (vecs[i].is_wr) wr_reg(vecs[i].off, vecs[i].data, vecs[i].be);
         else rd_chk(vecs[i].name, vecs[i].off, vecs[i].exp);
      end

      // Counter frozen with EN clear.
      do_reset();
      repeat (20) step();
      rd_chk("frozen_mtime", 0, 32'd0);

      // Prescale 3: one tick every 4 cycles.
      wr_reg(4, 32'h0000_0301, 4'hF);
      drive(reg_addr(0), 1'b1, 1'b0, 32'h0, 4'h0);
      prev = 32'd0; last_change = -1; cur = 32'd0;
      for (int c = 1; c <= 40; c++) begin
         step();
         #1 cur = bus_read_data;
         if (cur != prev) begin
            if (last_change >= 0) check("tick_interval", 64'(c - last_change), 64'd4);
            last_change = c;
            prev = cur;
         end
      end
      check("prescale_count", cur, 32'd10);
      idle();

      // Carry from low into high half.
      wr_reg(4, 32'h0, 4'hF);
      wr_reg(0, 32'hFFFF_FFFE, 4'hF);
      wr_reg(1, 32'h0, 4'hF);
      wr_reg(4, 32'h1, 4'hF);
      step();
      wr_reg(4, 32'h0, 4'hF);
      rd_chk("carry_hi", 1, 32'd1);
      rd_chk("carry_lo", 0, 32'd0);

      // Full 64-bit wrap.
      wr_reg(0, 32'hFFFF_FFFF, 4'hF);
      wr_reg(1, 32'hFFFF_FFFF, 4'hF);
      wr_reg(4, 32'h1, 4'hF);
      wr_reg(4, 32'h0, 4'hF);
      rd_chk("wrap_lo", 0, 32'd0);
      rd_chk("wrap_hi", 1, 32'd0);

      // Compare at 100 with interrupt enabled.
      wr_reg(0, 32'h0, 4'hF);
      wr_reg(3, 32'hFFFF_FFFF, 4'hF);
      wr_reg(2, 32'd100, 4'hF);
      wr_reg(3, 32'h0, 4'hF);
      wr_reg(5, 32'h1, 4'h1);
      rd_chk("pending_cleared_pre", 5, 32'd0);
      wr_reg(4, 32'h3, 4'hF);
      drive(reg_addr(0), 1'b1, 1'b0, 32'h0, 4'h0);
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
         #1;
         if (bus_read_data == 32'd100) begin
            found = 1'b1;
            check("irq_at_match_cycle", timer_irq, 0);
            step();
            #1 check("irq_after_match", timer_irq, 1);
         end else begin
            step();
         end
      end
      check("reach_100", found, 1);
      step();
      idle();
      wr_reg(5, 32'h1, 4'h1);
      rd_chk("pending_set_wins", 5, 32'd1);
      wr_reg(3, 32'hFFFF_FFFF, 4'hF);
      wr_reg(2, 32'hFFFF_FFFF, 4'hF);
      wr_reg(5, 32'h1, 4'h1);
      rd_chk("pending_cleared", 5, 32'd0);
      #1 check("irq_cleared", timer_irq, 0);

      // MTIME_LO write in a tick cycle wins and drops the increment.
      wr_reg(4, 32'h1, 4'hF);
      drive(reg_addr(1), 1'b1, 1'b0, 32'h0, 4'h0);
      #1 hi_before = bus_read_data;
      check("hi_before_model", hi_before, m_time[63:32]);
      idle();
      wr_reg(0, 32'd5, 4'hF);
      rd_chk("tick_write_lo", 0, 32'd5);
      rd_chk("tick_write_hi", 1, hi_before);

      // Out-of-block access.
      drive(BASE + 32'h20, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'hF);
      #1 check("outside_rdata", bus_read_data, 0);
      step();
      idle();
      for (int o = 2; o < 6; o++) begin
         drive(reg_addr(o), 1'b1, 1'b0, 32'h0, 4'h0);
         #1 check("outside_no_change", bus_read_data, model_read());
         step();
      end
      idle();

      // Reset mid-count, with a bus write in the reset cycle.
      wr_reg(4, 32'h0000_0203, 4'hF);
      repeat (5) step();
      drive(reg_addr(4), 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF);
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle();
      for (int i = 0; i < 6; i++) rd_chk(vecs[i].name, vecs[i].off, vecs[i].exp);
      #1 check("midrst_irq", timer_irq, 0);

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         logic [31:0] a;
         if ($urandom_range(7) == 0) a = $urandom;
         else a = BASE + 32'($urandom_range(7) * 4) + 32'($urandom_range(3));
         drive(a, 1'($urandom), 1'($urandom), $urandom, 4'($urandom));
         reset = ($urandom_range(63) == 0);
         #1;
         check("rand_rdata", bus_read_data, model_read());
         check("rand_irq", timer_irq, m_pend & m_ctrl[1]);
         step();
      end
      reset = 1'b0;
      idle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
